// File: rtl/addr_map_decoder.sv
// Address map decoder: programmable base/length rule table with a lockable
// config port and a registered, back-pressurable single-cycle lookup pipe.
module addr_map_decoder #(
  parameter int unsigned NrRules   = 10,
  parameter int unsigned AddrWidth = 64,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstBase   = '0,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstLength = '0,
  parameter logic [NrRules-1:0]                RstEnable = '1,
  localparam int unsigned IdxW = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // table configuration
  input  logic                 cfg_we_i,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_len_i,
  input  logic                 cfg_en_i,
  input  logic                 cfg_lock_i,
  output logic                 cfg_locked_o,
  output logic                 cfg_err_o,
  // lookup request
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  // lookup response
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [IdxW-1:0]      resp_idx_o,
  output logic                 resp_hit_o,
  output logic                 resp_multi_o,
  output logic [15:0]          miss_cnt_o
);

  logic [NrRules-1:0][AddrWidth-1:0] base_q;
  logic [NrRules-1:0][AddrWidth-1:0] len_q;
  logic [NrRules-1:0]                en_q;

  logic              idx_ok_c;
  logic              wr_c;
  logic              accept_c;
  logic [NrRules-1:0] match_c;
  logic              hit_c;
  logic              multi_c;
  logic [IdxW-1:0]   idx_c;

  assign idx_ok_c    = 32'(cfg_idx_i) < NrRules;
  assign wr_c        = cfg_we_i && !cfg_locked_o && idx_ok_c;
  assign req_ready_o = !resp_valid_o || resp_ready_i;
  assign accept_c    = req_valid_i && req_ready_o;

  // Per-rule range match; the subtraction is one bit wider so base+len never wraps.
  always_comb begin
    match_c = '0;
    for (int i = 0; i < int'(NrRules); i++) begin
      match_c[i] = en_q[i] && (len_q[i] != '0) && (req_addr_i >= base_q[i]) &&
                   (({1'b0, req_addr_i} - {1'b0, base_q[i]}) < {1'b0, len_q[i]});
    end
  end

  // Lowest-index priority resolve, flagging overlapping hits.
  always_comb begin
    hit_c   = 1'b0;
    multi_c = 1'b0;
    idx_c   = '0;
    for (int i = 0; i < int'(NrRules); i++) begin
      if (match_c[i]) begin
        if (hit_c) begin
          multi_c = 1'b1;
        end else begin
          hit_c = 1'b1;
          idx_c = IdxW'(i);
        end
      end
    end
  end

  // Rule table; a write lands at the edge, so a same-cycle lookup sees old contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q <= RstBase;
      len_q  <= RstLength;
      en_q   <= RstEnable;
    end else begin
      for (int i = 0; i < int'(NrRules); i++) begin
        if (wr_c && (cfg_idx_i == IdxW'(i))) begin
          base_q[i] <= cfg_base_i;
          len_q[i]  <= cfg_len_i;
          en_q[i]   <= cfg_en_i;
        end
      end
    end
  end

  // Sticky lock (write-then-lock) and one-cycle rejected-write pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_locked_o <= 1'b0;
      cfg_err_o    <= 1'b0;
    end else begin
      if (cfg_lock_i) begin
        cfg_locked_o <= 1'b1;
      end
      cfg_err_o <= cfg_we_i && (cfg_locked_o || !idx_ok_c);
    end
  end

  // Response register: load on accept, drop after handshake, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid_o <= 1'b0;
      resp_idx_o   <= '0;
      resp_hit_o   <= 1'b0;
      resp_multi_o <= 1'b0;
    end else if (accept_c) begin
      resp_valid_o <= 1'b1;
      resp_idx_o   <= idx_c;
      resp_hit_o   <= hit_c;
      resp_multi_o <= multi_c;
    end else if (resp_ready_i) begin
      resp_valid_o <= 1'b0;
    end
  end

  // Saturating count of accepted lookups that matched no rule.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      miss_cnt_o <= '0;
    end else if (accept_c && !hit_c && (miss_cnt_o != 16'hFFFF)) begin
      miss_cnt_o <= miss_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_addr_map_decoder.sv
// Directed self-checking bench for addr_map_decoder (10 rules, 64-bit addresses).
module tb_addr_map_decoder;

  localparam int unsigned NR = 10;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 4;
  localparam logic [NR-1:0][AW-1:0] RST_BASE = {64'h5000, {8{64'h0}}, 64'h8000_0000};
  localparam logic [NR-1:0][AW-1:0] RST_LEN  = {64'h100,  {8{64'h0}}, 64'h4000_0000};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_len = '0;
  logic          cfg_en = 1'b0;
  logic          cfg_lock = 1'b0;
  logic          cfg_locked;
  logic          cfg_err;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [IW-1:0] resp_idx;
  logic          resp_hit;
  logic          resp_multi;
  logic [15:0]   miss_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_miss = 0;

  addr_map_decoder #(
    .NrRules  (NR),
    .AddrWidth(AW),
    .RstBase  (RST_BASE),
    .RstLength(RST_LEN)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_we_i    (cfg_we),
    .cfg_idx_i   (cfg_idx),
    .cfg_base_i  (cfg_base),
    .cfg_len_i   (cfg_len),
    .cfg_en_i    (cfg_en),
    .cfg_lock_i  (cfg_lock),
    .cfg_locked_o(cfg_locked),
    .cfg_err_o   (cfg_err),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_idx_o  (resp_idx),
    .resp_hit_o  (resp_hit),
    .resp_multi_o(resp_multi),
    .miss_cnt_o  (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input logic [AW-1:0] b, input logic [AW-1:0] l,
                           input logic en, input logic lock);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_base = b; cfg_len = l; cfg_en = en; cfg_lock = lock;
    tick();
    cfg_we = 1'b0; cfg_lock = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [AW-1:0] a, input logic eh,
                        input int ei, input logic em);
    req_valid = 1'b1; req_addr = a; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    if (!eh && exp_miss < 65535) exp_miss++;
    chk({tag, ".valid"}, 64'(resp_valid), 64'd1);
    chk({tag, ".hit"},   64'(resp_hit),   64'(eh));
    chk({tag, ".idx"},   64'(resp_idx),   64'(ei));
    chk({tag, ".multi"}, 64'(resp_multi), 64'(em));
    chk({tag, ".miss"},  64'(miss_cnt),   64'(exp_miss));
    tick();
    chk({tag, ".drop"},  64'(resp_valid), 64'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".valid"},  64'(resp_valid), 64'd0);
    chk({tag, ".idx"},    64'(resp_idx),   64'd0);
    chk({tag, ".hit"},    64'(resp_hit),   64'd0);
    chk({tag, ".multi"},  64'(resp_multi), 64'd0);
    chk({tag, ".locked"}, 64'(cfg_locked), 64'd0);
    chk({tag, ".err"},    64'(cfg_err),    64'd0);
    chk({tag, ".miss"},   64'(miss_cnt),   64'd0);
    chk({tag, ".ready"},  64'(req_ready),  64'd1);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk_reset_state("rst0");

    // reset-loaded rules 0 and 9
    lookup("r0_top",  64'hBFFF_FFFF, 1'b1, 0, 1'b0);
    lookup("r0_past", 64'hC000_0000, 1'b0, 0, 1'b0);
    lookup("r9_rst",  64'h5010,      1'b1, 9, 1'b0);

    // rule at the very top of the address space
    cfg_write(2, 64'hFFFF_FFFF_FFFF_F000, 64'h2000, 1'b1, 1'b0);
    chk("w2.err", 64'(cfg_err), 64'd0);
    lookup("r2_max",   64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2, 1'b0);
    lookup("r2_wrap",  64'h0,                   1'b0, 0, 1'b0);
    lookup("r2_below", 64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 0, 1'b0);

    // overlapping rules 3 and 5
    cfg_write(3, 64'h1000_0000, 64'h1000,      1'b1, 1'b0);
    cfg_write(5, 64'h0F00_0000, 64'h0200_0000, 1'b1, 1'b0);
    lookup("ovl",   64'h1000_0000, 1'b1, 3, 1'b1);
    lookup("r5only", 64'h0F00_0000, 1'b1, 5, 1'b0);

    // out-of-range index is rejected with a single pulse
    cfg_write(12, 64'h7000_0000, 64'h100, 1'b1, 1'b0);
    chk("badidx.err", 64'(cfg_err), 64'd1);
    tick();
    chk("badidx.err_off", 64'(cfg_err), 64'd0);
    lookup("badidx_nowr", 64'h7000_0000, 1'b0, 0, 1'b0);

    // disabling a rule removes its match
    cfg_write(9, 64'h5000, 64'h100, 1'b0, 1'b0);
    lookup("r9_dis", 64'h5010, 1'b0, 0, 1'b0);

    // lookup in the same cycle as a write sees the old table
    cfg_we = 1'b1; cfg_idx = IW'(4); cfg_base = 64'h2000; cfg_len = 64'h10; cfg_en = 1'b1;
    req_valid = 1'b1; req_addr = 64'h2000; resp_ready = 1'b1;
    tick();
    cfg_we = 1'b0; req_valid = 1'b0;
    exp_miss++;
    chk("oldtab.hit",  64'(resp_hit),  64'd0);
    chk("oldtab.miss", 64'(miss_cnt),  64'(exp_miss));
    tick();
    lookup("newtab", 64'h2000, 1'b1, 4, 1'b0);

    // back-pressure: response held, request stalled for three cycles
    req_valid = 1'b1; req_addr = 64'h8000_0000; resp_ready = 1'b0;
    tick();
    req_addr = 64'h1000_0000;
    for (int k = 0; k < 3; k++) begin
      chk("bp.ready", 64'(req_ready),  64'd0);
      chk("bp.valid", 64'(resp_valid), 64'd1);
      chk("bp.idx",   64'(resp_idx),   64'd0);
      chk("bp.hit",   64'(resp_hit),   64'd1);
      chk("bp.multi", 64'(resp_multi), 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp.ready_rel", 64'(req_ready), 64'd1);
    tick();
    chk("b2b0.idx",   64'(resp_idx),   64'd3);
    chk("b2b0.multi", 64'(resp_multi), 64'd1);
    req_addr = 64'h0F00_0000;
    tick();
    chk("b2b1.valid", 64'(resp_valid), 64'd1);
    chk("b2b1.idx",   64'(resp_idx),   64'd5);
    chk("b2b1.ready", 64'(req_ready),  64'd1);
    req_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk("b2b2.idx",   64'(resp_idx),   64'd2);
    chk("b2b2.multi", 64'(resp_multi), 64'd0);
    req_valid = 1'b0;
    tick();
    chk("b2b.drop", 64'(resp_valid), 64'd0);
    chk("b2b.miss", 64'(miss_cnt), 64'(exp_miss));

    // write-then-lock, then a rejected write
    cfg_write(6, 64'h3000, 64'h100, 1'b1, 1'b1);
    chk("lock.locked", 64'(cfg_locked), 64'd1);
    chk("lock.err",    64'(cfg_err),    64'd0);
    lookup("lock_wr", 64'h3000, 1'b1, 6, 1'b0);
    cfg_write(6, 64'h9000, 64'h100, 1'b1, 1'b0);
    chk("locked_wr.err", 64'(cfg_err), 64'd1);
    tick();
    chk("locked_wr.err_off", 64'(cfg_err),    64'd0);
    chk("locked_wr.sticky",  64'(cfg_locked), 64'd1);
    lookup("locked_new", 64'h9000, 1'b0, 0, 1'b0);
    lookup("locked_old", 64'h3000, 1'b1, 6, 1'b0);

    // reset while a response is pending
    req_valid = 1'b1; req_addr = 64'h3000; resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("prerst.valid", 64'(resp_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    resp_ready = 1'b1;
    exp_miss = 0;
    chk_reset_state("rst1");
    lookup("rst_r6",  64'h3000,      1'b0, 0, 1'b0);
    lookup("rst_r0",  64'hBFFF_FFFF, 1'b1, 0, 1'b0);
    lookup("rst_r9",  64'h5010,      1'b1, 9, 1'b0);
    lookup("rst_r3",  64'h1000_0000, 1'b0, 0, 1'b0);
    lookup("rst_r2",  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 1'b0);

    // saturate the miss counter with a continuous miss stream
    req_valid = 1'b1; req_addr = 64'h7000_0000; resp_ready = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("sat.miss", 64'(miss_cnt), 64'hFFFF);
    chk("sat.hit",  64'(resp_hit), 64'd0);
    tick();
    chk("sat.hold", 64'(miss_cnt), 64'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
